// File: rtl/board_pkg.sv
// Shared definitions for the battleship board: cell encoding, board size and
// the colour palette. The game-logic FSM that writes the board memory uses the
// same package, so cell_t is the single source of truth for the encoding.
package board_pkg;

  localparam int unsigned GRID_N     = 10;
  // Wide enough for GRID_N*GRID_N cell indices.
  localparam int unsigned CELL_IDX_W = 7;

  typedef enum logic [1:0] {
    CellEmpty = 2'd0,
    CellShip  = 2'd1,
    CellMiss  = 2'd2,
    CellHit   = 2'd3
  } cell_t;

  localparam logic [11:0] ColBlank  = 12'h000;
  localparam logic [11:0] ColLine   = 12'h000;
  localparam logic [11:0] ColCursor = 12'hFF0;
  localparam logic [11:0] ColEmpty  = 12'h05A;
  localparam logic [11:0] ColShip   = 12'h888;
  localparam logic [11:0] ColMiss   = 12'h0AF;
  localparam logic [11:0] ColHit    = 12'hF00;

  function automatic logic [11:0] cell_color(input cell_t state);
    logic [11:0] col;
    col = ColEmpty;
    unique case (state)
      CellEmpty: col = ColEmpty;
      CellShip:  col = ColShip;
      CellMiss:  col = ColMiss;
      CellHit:   col = ColHit;
      default:   col = ColEmpty;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed between drawing stages.
//   hcount/vcount : 11-bit pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12-bit colour (4:4:4)
// Modport in is the consumer view, out the producer view.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/vga_delay.sv
// Register chain that delays a packed group of VGA timing fields by DEPTH
// clock cycles, with synchronous active-high reset clearing every stage.
//   clk  : pixel clock
//   rst  : synchronous active-high reset
//   din  : WIDTH-bit field group entering the chain
//   dout : the same group DEPTH cycles later
module vga_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_delay: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_board.sv
// Two-stage overlay stage that draws the battleship board onto the pixel
// stream: grid lines, per-cell colour from the board memory and a cursor rim.
//   clk        : pixel clock
//   rst        : synchronous active-high reset
//   vga_in     : incoming timing + rgb
//   vga_out    : same timing delayed by 2 cycles + recoloured rgb
//   cell_addr  : board memory address row*GRID_N+col (registered, 0 outside board)
//   cell_state : board memory data for cell_addr, consumed in stage 2
//   cursor_en  : enable cursor highlight
//   cursor_x/y : cursor cell column/row
// Stage 1 decodes position and registers flags plus the memory address; stage 2
// combines the flags with cell_state to produce the final colour.
module draw_board #(
  parameter logic [10:0] X_POS     = 11'd80,
  parameter logic [10:0] Y_POS     = 11'd60,
  parameter int unsigned CELL_SIZE = 32,
  parameter int unsigned GRID_N    = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  vga_if.in                                vga_in,
  vga_if.out                               vga_out,
  output logic [board_pkg::CELL_IDX_W-1:0] cell_addr,
  input  logic [1:0]                       cell_state,
  input  logic                             cursor_en,
  input  logic [3:0]                       cursor_x,
  input  logic [3:0]                       cursor_y
);
  import board_pkg::*;

  if ((CELL_SIZE < 8) || ((CELL_SIZE & (CELL_SIZE - 1)) != 0)) begin : g_bad_cell_size
    $error("draw_board: CELL_SIZE must be a power of two and at least 8");
  end

  if ((GRID_N * GRID_N) > (1 << CELL_IDX_W)) begin : g_bad_grid
    $error("draw_board: GRID_N*GRID_N does not fit in cell_addr");
  end

  localparam int unsigned Shift   = $clog2(CELL_SIZE);
  localparam logic [10:0] GridPix = 11'(GRID_N * CELL_SIZE);
  localparam logic [10:0] GridN11 = 11'(GRID_N);
  localparam int unsigned DlyW    = 26;

  // Cursor rim: two pixels inside each cell edge, skipping the grid line itself.
  function automatic logic on_rim(input logic [Shift-1:0] o);
    return (o == Shift'(1)) || (o == Shift'(2)) ||
           (o == Shift'(CELL_SIZE - 2)) || (o == Shift'(CELL_SIZE - 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1 decode
  // ---------------------------------------------------------------------------
  logic [10:0]      lx, ly;
  logic [10:0]      col, row;
  logic [Shift-1:0] ox, oy;
  logic             in_grid_x, in_grid_y;
  logic             in_grid_d, is_line_d, in_cell_d, cursor_hit_d, blank_d;
  logic [10:0]      addr_full;
  logic [CELL_IDX_W-1:0] cell_addr_d;

  // lx/ly wrap left of / above the board; the >= compare rejects those.
  assign lx  = vga_in.hcount - X_POS;
  assign ly  = vga_in.vcount - Y_POS;
  assign col = lx >> Shift;
  assign row = ly >> Shift;
  assign ox  = lx[Shift-1:0];
  assign oy  = ly[Shift-1:0];

  assign in_grid_x = (vga_in.hcount >= X_POS) && (lx <= GridPix);
  assign in_grid_y = (vga_in.vcount >= Y_POS) && (ly <= GridPix);
  assign in_grid_d = in_grid_x && in_grid_y;
  assign is_line_d = in_grid_d && ((ox == '0) || (oy == '0));
  // Excludes the closing line at lx/ly == GridPix, whose col/row is GRID_N.
  assign in_cell_d = in_grid_d && (col < GridN11) && (row < GridN11);

  assign addr_full   = row * GridN11 + col;
  assign cell_addr_d = in_cell_d ? addr_full[CELL_IDX_W-1:0] : '0;

  assign cursor_hit_d = cursor_en && in_cell_d && !is_line_d &&
                        (col == {7'd0, cursor_x}) && (row == {7'd0, cursor_y}) &&
                        (on_rim(ox) || on_rim(oy));

  assign blank_d = vga_in.hblnk || vga_in.vblnk;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [11:0]           rgb1_q;
  logic                  blank1_q;
  logic                  in_grid_q;
  logic                  is_line_q;
  logic                  cursor_hit_q;
  logic [CELL_IDX_W-1:0] cell_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb1_q       <= '0;
      blank1_q     <= 1'b0;
      in_grid_q    <= 1'b0;
      is_line_q    <= 1'b0;
      cursor_hit_q <= 1'b0;
      cell_addr_q  <= '0;
    end else begin
      rgb1_q       <= vga_in.rgb;
      blank1_q     <= blank_d;
      in_grid_q    <= in_grid_d;
      is_line_q    <= is_line_d;
      cursor_hit_q <= cursor_hit_d;
      cell_addr_q  <= cell_addr_d;
    end
  end

  assign cell_addr = cell_addr_q;

  // ---------------------------------------------------------------------------
  // Stage 2: colour select and output register
  // ---------------------------------------------------------------------------
  logic [11:0] rgb2_d, rgb2_q;

  always_comb begin
    rgb2_d = ColBlank;
    if (blank1_q) begin
      rgb2_d = ColBlank;
    end else if (!in_grid_q) begin
      rgb2_d = rgb1_q;
    end else if (cursor_hit_q) begin
      rgb2_d = ColCursor;
    end else if (is_line_q) begin
      rgb2_d = ColLine;
    end else begin
      rgb2_d = cell_color(cell_t'(cell_state));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb2_q <= '0;
    end else begin
      rgb2_q <= rgb2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timing fields: two-cycle delay matching the rgb path
  // ---------------------------------------------------------------------------
  logic [DlyW-1:0] dly_in, dly_out;

  assign dly_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                   vga_in.hblnk, vga_in.vblnk};

  vga_delay #(
    .DEPTH(2),
    .WIDTH(DlyW)
  ) u_vga_delay (
    .clk (clk),
    .rst (rst),
    .din (dly_in),
    .dout(dly_out)
  );

  assign vga_out.hcount = dly_out[25:15];
  assign vga_out.vcount = dly_out[14:4];
  assign vga_out.hsync  = dly_out[3];
  assign vga_out.vsync  = dly_out[2];
  assign vga_out.hblnk  = dly_out[1];
  assign vga_out.vblnk  = dly_out[0];
  assign vga_out.rgb    = rgb2_q;

endmodule

// File: tb/tb_draw_board.sv
module tb_draw_board;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cell_addr;
  logic [1:0] cell_state;
  logic       cursor_en;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_if vin ();
  vga_if vout ();

  draw_board dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vin),
    .vga_out   (vout),
    .cell_addr (cell_addr),
    .cell_state(cell_state),
    .cursor_en (cursor_en),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y)
  );

  // Board memory; the DUT's cell_addr register acts as the read-address
  // register, so data is valid in the cycle after the pixel was sampled.
  logic [1:0] mem [128];
  assign cell_state = mem[cell_addr];

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [6:0]  addr;
  } exp_t;

  exp_t h1, h2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_pix(input int h, input int v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] rgb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one pixel, check its address after one edge and colour after two.
  task automatic pix_check(input string tag, input int h, input int v, input logic hb,
                           input logic [11:0] rgb_in, input logic [6:0] exp_addr,
                           input logic [11:0] exp_rgb);
    set_pix(h, v, 1'b1, 1'b0, hb, 1'b0, rgb_in);
    step();
    check({tag, "_addr"}, 64'(cell_addr), 64'(exp_addr));
    set_pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    check({tag, "_rgb"}, 64'(vout.rgb), 64'(exp_rgb));
  endtask

  // Reference: board at (80,60), 32-pixel cells, 10x10, geometry by division.
  function automatic exp_t model(input logic [10:0] h, input logic [10:0] v, input logic hs,
                                 input logic vs, input logic hb, input logic vb,
                                 input logic [11:0] rgb_in);
    exp_t e;
    int   lx, ly, c, r, ox, oy;
    bit   grid, line, cur;
    e = '0;
    e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    grid = (h >= 80) && (h <= 400) && (v >= 60) && (v <= 380);
    if (grid) begin
      lx = int'(h) - 80; ly = int'(v) - 60;
      c = lx / 32; r = ly / 32; ox = lx % 32; oy = ly % 32;
      if (c < 10 && r < 10) e.addr = 7'(r * 10 + c);
      line = (ox == 0) || (oy == 0);
      cur  = cursor_en && (c == int'(cursor_x)) && (r == int'(cursor_y)) && !line &&
             ((ox inside {1, 2, 30, 31}) || (oy inside {1, 2, 30, 31}));
    end
    if (hb || vb) e.rgb = 12'h000;
    else if (!grid) e.rgb = rgb_in;
    else if (cur) e.rgb = 12'hFF0;
    else if (line) e.rgb = 12'h000;
    else begin
      case (mem[r * 10 + c])
        2'd0: e.rgb = 12'h05A;
        2'd1: e.rgb = 12'h888;
        2'd2: e.rgb = 12'h0AF;
        default: e.rgb = 12'hF00;
      endcase
    end
    return e;
  endfunction

  task automatic fstep();
    exp_t e;
    e = model(vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb);
    @(posedge clk);
    if (rst) begin
      h1 = '0;
      h2 = '0;
    end else begin
      h2 = h1;
      h1 = e;
    end
    @(negedge clk);
    check("frame_out",
          64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
               vout.rgb}),
          64'({h2.h, h2.v, h2.hs, h2.vs, h2.hb, h2.vb, h2.rgb}));
    check("frame_addr", 64'(cell_addr), 64'(h1.addr));
  endtask

  int vlist [23] = '{58, 59, 60, 61, 75, 91, 92, 134, 188, 252, 284, 285, 286, 300, 314,
                     315, 316, 353, 379, 380, 381, 420, 600};

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 2'd0;
    mem[0]  = 2'd2;   // MISS
    mem[23] = 2'd3;   // HIT
    mem[74] = 2'd1;   // SHIP, cursor cell (col 4, row 7)
    mem[99] = 2'd1;   // SHIP

    cursor_en = 1'b0;
    cursor_x  = 4'd0;
    cursor_y  = 4'd0;
    rst       = 1'b1;
    set_pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(negedge clk);

    // Reset with random input traffic
    for (int i = 0; i < 3; i++) begin
      set_pix(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
      step();
    end
    check("reset_out", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
                           vout.vblnk, vout.rgb}), 64'd0);
    check("reset_addr", 64'(cell_addr), 64'd0);

    rst = 1'b0;
    set_pix(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    check("post_reset_gap", 64'(vout.hcount), 64'd0);
    step();
    check("post_reset_h5", 64'(vout.hcount), 64'd5);

    // Lookup and cell colours
    pix_check("hit23",    186, 134, 1'b0, 12'h123, 7'd23, 12'hF00);
    pix_check("miss0",     85,  65, 1'b0, 12'h123, 7'd0,  12'h0AF);
    pix_check("ship99",   373, 353, 1'b0, 12'h123, 7'd99, 12'h888);
    pix_check("empty55",  245, 225, 1'b0, 12'h123, 7'd55, 12'h05A);

    // Lines and edges
    pix_check("line_lx0",    80, 134, 1'b0, 12'hABC, 7'd20, 12'h000);
    pix_check("line_lx160", 240, 134, 1'b0, 12'hABC, 7'd25, 12'h000);
    pix_check("line_lx320", 400, 134, 1'b0, 12'hABC, 7'd0,  12'h000);
    pix_check("pass_lx321", 401, 134, 1'b0, 12'hABC, 7'd0,  12'hABC);
    pix_check("pass_left",   10, 134, 1'b0, 12'h357, 7'd0,  12'h357);
    pix_check("line_ly320", 186, 380, 1'b0, 12'hABC, 7'd0,  12'h000);
    pix_check("pass_ly321", 186, 381, 1'b0, 12'hABC, 7'd0,  12'hABC);

    // Cursor at (4,7)
    cursor_en = 1'b1; cursor_x = 4'd4; cursor_y = 4'd7;
    pix_check("cur_ox1",    209, 300, 1'b0, 12'h111, 7'd74, 12'hFF0);
    pix_check("cur_mid",    224, 300, 1'b0, 12'h111, 7'd74, 12'h888);
    pix_check("cur_ox31",   239, 300, 1'b0, 12'h111, 7'd74, 12'hFF0);
    pix_check("cur_oy30",   224, 314, 1'b0, 12'h111, 7'd74, 12'hFF0);
    pix_check("cur_line",   208, 300, 1'b0, 12'h111, 7'd74, 12'h000);
    cursor_x = 4'd12;
    pix_check("cur_out_x",  209, 300, 1'b0, 12'h111, 7'd74, 12'h888);
    cursor_x = 4'd4; cursor_en = 1'b0;
    pix_check("cur_off",    209, 300, 1'b0, 12'h111, 7'd74, 12'h888);

    // Blanking inside the grid
    set_pix(186, 134, 1'b1, 1'b0, 1'b1, 1'b0, 12'h777);
    step();
    set_pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    check("blank_rgb",   64'(vout.rgb), 64'h000);
    check("blank_hsync", 64'(vout.hsync), 64'd1);
    check("blank_hblnk", 64'(vout.hblnk), 64'd1);

    // Frame sweep against the reference model, with a mid-line reset
    cursor_en = 1'b1; cursor_x = 4'd4; cursor_y = 4'd7;
    rst = 1'b1;
    fstep();
    rst = 1'b0;
    for (int li = 0; li < 23; li++) begin
      for (int h = 0; h < 440; h++) begin
        set_pix(h, vlist[li], (h >= 430) && (h < 436), (vlist[li] >= 600),
                (h >= 420), (vlist[li] >= 600), 12'((h * 37) ^ (vlist[li] * 11)));
        rst = (li == 7) && (h == 200 || h == 201);
        fstep();
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
